// File: rtl/fft_peak_detect_pkg.sv
// fft_peak_detect shared constants and types.
// Default geometry of the FFT output stream.
package fft_peak_detect_pkg;

  localparam int DEF_DATA_WID     = 16;
  localparam int DEF_FFT_LEN      = 64;
  localparam int DEF_LOG2_FFT_LEN = 6;
  localparam int DEF_PWR_WID      = 2 * DEF_DATA_WID;

  typedef logic [DEF_PWR_WID-1:0]      pwr_t;
  typedef logic [DEF_LOG2_FFT_LEN-1:0] bin_t;

  typedef struct packed {
    logic first;
    logic last;
    bin_t bin;
  } tag_t;

endpackage

// File: rtl/fft_peak_detect_if.sv
// fft_peak_detect stream bundle.
// Input bin stream plus power and peak result streams.
interface fft_peak_detect_if
  import fft_peak_detect_pkg::*;
#(
  parameter int DATA_WID     = DEF_DATA_WID,
  parameter int LOG2_FFT_LEN = DEF_LOG2_FFT_LEN
);

  localparam int PWR_WID = 2 * DATA_WID;

  logic                       val_i;
  logic signed [DATA_WID-1:0] fft_data_re_i;
  logic signed [DATA_WID-1:0] fft_data_im_i;

  logic                    pwr_val_o;
  logic [PWR_WID-1:0]      pwr_o;
  logic [LOG2_FFT_LEN-1:0] pwr_bin_o;

  logic                    peak_val_o;
  logic [PWR_WID-1:0]      peak_pwr_o;
  logic [LOG2_FFT_LEN-1:0] peak_bin_o;

  logic                    frame_err_o;

  modport master (
    output val_i,
    output fft_data_re_i,
    output fft_data_im_i,
    input  pwr_val_o,
    input  pwr_o,
    input  pwr_bin_o,
    input  peak_val_o,
    input  peak_pwr_o,
    input  peak_bin_o,
    input  frame_err_o
  );

  modport slave (
    input  val_i,
    input  fft_data_re_i,
    input  fft_data_im_i,
    output pwr_val_o,
    output pwr_o,
    output pwr_bin_o,
    output peak_val_o,
    output peak_pwr_o,
    output peak_bin_o,
    output frame_err_o
  );

endinterface

// File: rtl/fft_peak_detect_mag_sq.sv
// fft_mag_sq: two-stage |X|^2 pipeline.
// Valid and frame tags ride alongside the data.
module fft_mag_sq
  import fft_peak_detect_pkg::*;
#(
  parameter int DATA_WID     = DEF_DATA_WID,
  parameter int LOG2_FFT_LEN = DEF_LOG2_FFT_LEN,
  localparam int PWR_WID     = 2 * DATA_WID
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_val,
  input  logic signed [DATA_WID-1:0]    in_re,
  input  logic signed [DATA_WID-1:0]    in_im,
  input  logic                          in_first,
  input  logic                          in_last,
  input  logic [LOG2_FFT_LEN-1:0]       in_bin,
  output logic                          out_val,
  output logic [PWR_WID-1:0]            out_pwr,
  output logic                          out_first,
  output logic                          out_last,
  output logic [LOG2_FFT_LEN-1:0]       out_bin
);

  logic signed [PWR_WID-1:0] re_x;
  logic signed [PWR_WID-1:0] im_x;

  logic                    s1_val;
  logic [PWR_WID-1:0]      s1_sq_re;
  logic [PWR_WID-1:0]      s1_sq_im;
  logic                    s1_first;
  logic                    s1_last;
  logic [LOG2_FFT_LEN-1:0] s1_bin;

  assign re_x = {{DATA_WID{in_re[DATA_WID-1]}}, in_re};
  assign im_x = {{DATA_WID{in_im[DATA_WID-1]}}, im_sgn_fix(in_im)};

  function automatic logic [DATA_WID-1:0] im_sgn_fix(
    input logic [DATA_WID-1:0] v
  );
    return v;
  endfunction

  // Stage 1: square each component; a square is never negative.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_val   <= 1'b0;
      s1_sq_re <= '0;
      s1_sq_im <= '0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_bin   <= '0;
    end else begin
      s1_val   <= in_val;
      s1_sq_re <= re_x * re_x;
      s1_sq_im <= im_x * im_x;
      s1_first <= in_first;
      s1_last  <= in_last;
      s1_bin   <= in_bin;
    end
  end

  // Stage 2: sum of squares; peaks at 2^(PWR_WID-1), no carry out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_val   <= 1'b0;
      out_pwr   <= '0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      out_bin   <= '0;
    end else begin
      out_val   <= s1_val;
      out_pwr   <= s1_sq_re + s1_sq_im;
      out_first <= s1_first;
      out_last  <= s1_last;
      out_bin   <= s1_bin;
    end
  end

endmodule

// File: rtl/fft_peak_detect.sv
// fft_peak_detect: power spectrum and per-frame peak.
// Counts bins, flags truncation, tracks the max bin.
module fft_peak_detect
  import fft_peak_detect_pkg::*;
#(
  parameter int DATA_WID     = DEF_DATA_WID,
  parameter int FFT_LEN      = DEF_FFT_LEN,
  parameter int LOG2_FFT_LEN = DEF_LOG2_FFT_LEN,
  parameter bit SKIP_DC      = 1'b0,
  localparam int PWR_WID     = 2 * DATA_WID
) (
  input logic              clk,
  input logic              rst_n,
  fft_peak_detect_if.slave bus
);

  localparam logic [LOG2_FFT_LEN-1:0] LAST_BIN =
    LOG2_FFT_LEN'(FFT_LEN - 1);

  logic [LOG2_FFT_LEN-1:0] in_cnt;
  logic                    in_first;
  logic                    in_last;
  logic                    trunc;

  logic                    s2_val;
  logic [PWR_WID-1:0]      s2_pwr;
  logic                    s2_first;
  logic                    s2_last;
  logic [LOG2_FFT_LEN-1:0] s2_bin;

  logic [PWR_WID-1:0]      cur_max;
  logic [LOG2_FFT_LEN-1:0] cur_bin;
  logic [PWR_WID-1:0]      nxt_max;
  logic [LOG2_FFT_LEN-1:0] nxt_bin;

  logic                    peak_val;
  logic [PWR_WID-1:0]      peak_pwr;
  logic [LOG2_FFT_LEN-1:0] peak_bin;
  logic                    frame_err;

  assign in_first = bus.val_i && (in_cnt == '0);
  assign in_last  = bus.val_i && (in_cnt == LAST_BIN);
  assign trunc    = !bus.val_i && (in_cnt != '0);

  // Bin counter; any gap inside a frame restarts at bin 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_cnt <= '0;
    end else if (!bus.val_i) begin
      in_cnt <= '0;
    end else if (in_cnt == LAST_BIN) begin
      in_cnt <= '0;
    end else begin
      in_cnt <= in_cnt + 1'b1;
    end
  end

  fft_mag_sq #(
    .DATA_WID     (DATA_WID),
    .LOG2_FFT_LEN (LOG2_FFT_LEN)
  ) u_mag_sq (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_val    (bus.val_i),
    .in_re     (bus.fft_data_re_i),
    .in_im     (bus.fft_data_im_i),
    .in_first  (in_first),
    .in_last   (in_last),
    .in_bin    (in_cnt),
    .out_val   (s2_val),
    .out_pwr   (s2_pwr),
    .out_first (s2_first),
    .out_last  (s2_last),
    .out_bin   (s2_bin)
  );

  // Running max including the current bin; ties keep the older bin.
  always_comb begin
    nxt_max = cur_max;
    nxt_bin = cur_bin;
    if (s2_first) begin
      nxt_max = SKIP_DC ? '0 : s2_pwr;
      nxt_bin = '0;
    end else if (s2_pwr > cur_max) begin
      nxt_max = s2_pwr;
      nxt_bin = s2_bin;
    end
  end

  // Tracker state advances only on valid stage-2 bins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_max <= '0;
      cur_bin <= '0;
    end else if (s2_val) begin
      cur_max <= nxt_max;
      cur_bin <= nxt_bin;
    end
  end

  // Result registers, loaded only by a last-tagged bin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_val  <= 1'b0;
      peak_pwr  <= '0;
      peak_bin  <= '0;
      frame_err <= 1'b0;
    end else begin
      peak_val  <= s2_val && s2_last;
      frame_err <= trunc;
      if (s2_val && s2_last) begin
        peak_pwr <= nxt_max;
        peak_bin <= nxt_bin;
      end
    end
  end

  assign bus.pwr_val_o   = s2_val;
  assign bus.pwr_o       = s2_pwr;
  assign bus.pwr_bin_o   = s2_bin;
  assign bus.peak_val_o  = peak_val;
  assign bus.peak_pwr_o  = peak_pwr;
  assign bus.peak_bin_o  = peak_bin;
  assign bus.frame_err_o = frame_err;

endmodule

// File: doc/fft_peak_detect.md
Name: fft_peak_detect

Overview:
- Sits directly downstream of the serial FFT output stage. It consumes one FFT frame as FFT_LEN consecutive complex bins, in order bin 0 first, one bin per cycle with val_i high.
- Computes a pipelined power spectrum |X|^2 and streams it out per bin.
- Tracks the bin with the maximum power and reports it once per completed frame.
- Flags frames that are truncated mid-stream.

Parameters:
- DATA_WID, 16, bit width of signed re/im input samples (`DATA_WID from the shared defines).
- FFT_LEN, 64, bins per frame (`FFT_LEN).
- LOG2_FFT_LEN, 6, bin index width (`LOG2_FFT_LEN).
- SKIP_DC, 0, when 1, bin 0 is excluded from the peak search but its power is still streamed.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- val_i  input  1  input bin valid; high for FFT_LEN consecutive cycles per frame.
- fft_data_re_i  input  DATA_WID  signed real part of current bin.
- fft_data_im_i  input  DATA_WID  signed imaginary part of current bin.
- pwr_val_o  output  1  pwr_o / pwr_bin_o valid.
- pwr_o  output  2*DATA_WID  unsigned re^2+im^2.
- pwr_bin_o  output  LOG2_FFT_LEN  bin index of pwr_o.
- peak_val_o  output  1  one-cycle pulse: peak result valid.
- peak_pwr_o  output  2*DATA_WID  maximum power of last complete frame.
- peak_bin_o  output  LOG2_FFT_LEN  bin index of that maximum.
- frame_err_o  output  1  one-cycle pulse: frame truncated.

Behaviour:
- Reset: all outputs 0; in_cnt=0; pipeline valid flags 0; peak tracker cleared.
- Input counter:
  - in_cnt increments on each val_i cycle and wraps FFT_LEN-1 -> 0.
  - Tags: first = (in_cnt==0), last = (in_cnt==FFT_LEN-1), bin = in_cnt. Tags travel with data through the pipeline.
- Stage 1 (registered): sq_re = re*re, sq_im = im*im. Signed multiply, 2*DATA_WID-bit products, non-negative.
- Stage 2 (registered): pwr = sq_re + sq_im.
  - Maximum is 2^(2*DATA_WID-1), at re = im = -2^(DATA_WID-1). It fits 2*DATA_WID bits unsigned, so no saturation is needed.
- Latency: pwr_val_o/pwr_o/pwr_bin_o asserted exactly 2 cycles after the val_i sample. Throughput is 1 bin/cycle; back-to-back frames carry no bubble.
- Peak tracker (operates on stage-2 outputs):
  - On a first-tagged bin: load cur_max=pwr, cur_bin=0 unconditionally. If SKIP_DC=1, load cur_max=0, cur_bin=0 instead, so bin 0 can never win.
  - Otherwise update when pwr > cur_max (strict). On ties the lowest bin is kept.
  - On a last-tagged bin: the final compare includes that bin. On the next cycle (3 cycles after the last val_i sample), peak_val_o=1 for one cycle and peak_pwr_o/peak_bin_o take the final values.
  - peak_pwr_o/peak_bin_o hold until the next peak_val_o.
  - If a new frame's first bin arrives in the same cycle as the previous frame's peak pulse, both proceed independently. The tracker for the new frame must not corrupt the registered peak outputs.
- Truncation: val_i=0 while in_cnt!=0 causes:
  - frame_err_o=1 for that cycle;
  - in_cnt reset to 0;
  - no last tag is ever generated, so no peak_val_o for that frame.
  - Partial bins already in the pipeline still appear on pwr_val_o.
  - The next val_i starts a fresh frame at bin 0.
- val_i=0 with in_cnt==0 (idle): no action, no error.
- Reset asserted mid-frame: immediate clear of all state. No peak or error pulse is produced for the interrupted frame.
- No backpressure: the consumer must accept every pwr_val_o/peak_val_o cycle.

Decomposition:
- Shared defines header: DATA_WID, FFT_LEN, LOG2_FFT_LEN, and a derived PWR_WID = 2*DATA_WID macro.
- One sub-module, fft_mag_sq: 2-stage pipelined squarer/adder carrying valid, first, last and bin tags with a fixed latency of 2.
- fft_peak_detect contains the input counter, truncation detect, peak tracker and output registers.

Test Plan:
- Single frame, all bins 0 except bin 5 = (3,-4) -> pwr_o=25 at bin 5 two cycles after its input; peak_val_o 3 cycles after bin 63 input with peak_pwr_o=25, peak_bin_o=5; frame_err_o never asserts.
- Extreme values, bin 10 = (-32768,-32768), others (32767,0) -> pwr_o=0x8000_0000 at bin 10, 0x3FFF_0001 elsewhere; peak_bin_o=10.
- Tie: bins 7 and 20 both (100,0) = max -> peak_bin_o=7, peak_pwr_o=10000.
- SKIP_DC=1, bin 0 = (1000,0), bin 33 = (10,10) -> peak_bin_o=33, peak_pwr_o=200; pwr_o at bin 0 still 1000000.
- Two back-to-back frames with no gap, peaks at bin 2 then bin 60 -> two peak_val_o pulses exactly 64 cycles apart with bins 2 and 60; pwr_val_o continuous for 128 cycles.
- Truncation: val_i drops after 40 bins -> frame_err_o pulse that cycle, 40 pwr_val_o cycles, no peak_val_o. A following full frame reports the correct peak with bin indices restarting at 0.
